// File: rtl/vinsn_issue_queue.sv
// Vector instruction issue queue: buffers scalar-core offers in a circular FIFO
// and issues them to rvv_core under an outstanding-instruction credit limit.
package vinsn_issue_queue_pkg;

    typedef logic [7:0]  insn_id_t;
    typedef logic [31:0] xlen_t;

    typedef struct packed {
        logic [7:0]  vtype;
        logic [15:0] vl;
    } vec_context_t;

    typedef struct packed {
        logic [31:0]  insn;
        insn_id_t     insn_id;
        xlen_t        scalar_reg;
        vec_context_t vec_context;
    } entry_t;

endpackage

module vinsn_issue_queue
    import vinsn_issue_queue_pkg::*;
#(
    parameter int unsigned Depth          = 4,
    parameter int unsigned MaxOutstanding = 4
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,

    input  logic                                valid_i,
    output logic                                ready_o,
    input  logic [31:0]                         insn_i,
    input  insn_id_t                            insn_id_i,
    input  xlen_t                               scalar_reg_i,
    input  vec_context_t                        vec_context_i,
    input  logic                                flush_i,

    output logic                                core_valid_o,
    input  logic                                core_ready_i,
    output logic [31:0]                         core_insn_o,
    output insn_id_t                            core_insn_id_o,
    output xlen_t                               core_scalar_reg_o,
    output vec_context_t                        core_vec_context_o,
    input  logic                                core_done_i,

    output logic [$clog2(Depth):0]              count_o,
    output logic [$clog2(MaxOutstanding):0]     outstanding_o,
    output logic                                done_underflow_o
);

    localparam int unsigned PtrW = $clog2(Depth);
    localparam int unsigned CntW = $clog2(Depth) + 1;
    localparam int unsigned OutW = $clog2(MaxOutstanding) + 1;

    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic [OutW-1:0] outst_q, outst_d;
    logic            underflow_q, underflow_d;

    entry_t          mem_q [Depth];
    entry_t          wr_entry;
    entry_t          head_entry;

    logic            push;
    logic            pop;

    // Handshakes depend only on registered state plus the flush request,
    // so a pop can never free a slot for a push in the same cycle.
    assign ready_o      = (count_q < CntW'(Depth)) && !flush_i;
    assign core_valid_o = (count_q != '0) && (outst_q < OutW'(MaxOutstanding)) && !flush_i;
    assign push         = valid_i && ready_o;
    assign pop          = core_valid_o && core_ready_i;

    assign wr_entry = '{
        insn:        insn_i,
        insn_id:     insn_id_i,
        scalar_reg:  scalar_reg_i,
        vec_context: vec_context_i
    };

    assign head_entry         = mem_q[rd_ptr_q];
    assign core_insn_o        = head_entry.insn;
    assign core_insn_id_o     = head_entry.insn_id;
    assign core_scalar_reg_o  = head_entry.scalar_reg;
    assign core_vec_context_o = head_entry.vec_context;

    assign count_o          = count_q;
    assign outstanding_o    = outst_q;
    assign done_underflow_o = underflow_q;

    // Queue pointer/occupancy update; flush overrides both handshakes.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + CntW'(1);
                2'b01:   count_d = count_q - CntW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Outstanding credit tracking; a stray done at zero is recorded, not applied.
    always_comb begin
        outst_d     = outst_q;
        underflow_d = underflow_q;
        case ({pop, core_done_i})
            2'b10: outst_d = outst_q + OutW'(1);
            2'b01: begin
                if (outst_q != '0) outst_d = outst_q - OutW'(1);
                else               underflow_d = 1'b1;
            end
            default: outst_d = outst_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            outst_q     <= '0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            outst_q     <= outst_d;
            underflow_q <= underflow_d;
        end
    end

    // Payload storage carries no reset; occupancy alone decides validity.
    always_ff @(posedge clk_i) begin
        if (push) mem_q[wr_ptr_q] <= wr_entry;
    end

endmodule

// File: tb/tb_vinsn_issue_queue.sv
// Directed scenario bench for vinsn_issue_queue (Depth=4, MaxOutstanding=2).
module tb_vinsn_issue_queue;
    import vinsn_issue_queue_pkg::*;

    logic         clk_i = 1'b0;
    logic         rst_ni;
    logic         valid_i;
    logic         ready_o;
    logic [31:0]  insn_i;
    insn_id_t     insn_id_i;
    xlen_t        scalar_reg_i;
    vec_context_t vec_context_i;
    logic         flush_i;
    logic         core_valid_o;
    logic         core_ready_i;
    logic [31:0]  core_insn_o;
    insn_id_t     core_insn_id_o;
    xlen_t        core_scalar_reg_o;
    vec_context_t core_vec_context_o;
    logic         core_done_i;
    logic [2:0]   count_o;
    logic [1:0]   outstanding_o;
    logic         done_underflow_o;

    int n_chk  = 0;
    int n_pass = 0;

    vinsn_issue_queue #(.Depth(4), .MaxOutstanding(2)) dut (
        .clk_i              (clk_i),
        .rst_ni             (rst_ni),
        .valid_i            (valid_i),
        .ready_o            (ready_o),
        .insn_i             (insn_i),
        .insn_id_i          (insn_id_i),
        .scalar_reg_i       (scalar_reg_i),
        .vec_context_i      (vec_context_i),
        .flush_i            (flush_i),
        .core_valid_o       (core_valid_o),
        .core_ready_i       (core_ready_i),
        .core_insn_o        (core_insn_o),
        .core_insn_id_o     (core_insn_id_o),
        .core_scalar_reg_o  (core_scalar_reg_o),
        .core_vec_context_o (core_vec_context_o),
        .core_done_i        (core_done_i),
        .count_o            (count_o),
        .outstanding_o      (outstanding_o),
        .done_underflow_o   (done_underflow_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic offer(input int id);
        valid_i       = 1'b1;
        insn_id_i     = 8'(id);
        insn_i        = 32'h1000_0000 + 32'(id);
        scalar_reg_i  = 32'(id * 3);
        vec_context_i = '{vtype: 8'(id), vl: 16'(id * 16)};
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        valid_i = 1'b0; core_ready_i = 1'b0; core_done_i = 1'b0; flush_i = 1'b0;
        insn_i = '0; insn_id_i = '0; scalar_reg_i = '0; vec_context_i = '0;
        #12;
        n_chk++; if (count_o !== 3'd0) $display("FAIL rst_count: got %0d want 0", count_o); else n_pass++;
        n_chk++; if (outstanding_o !== 2'd0) $display("FAIL rst_outst: got %0d want 0", outstanding_o); else n_pass++;
        n_chk++; if (done_underflow_o !== 1'b0) $display("FAIL rst_uflow: got %b want 0", done_underflow_o); else n_pass++;
        n_chk++; if (ready_o !== 1'b1) $display("FAIL rst_ready: got %b want 1", ready_o); else n_pass++;
        n_chk++; if (core_valid_o !== 1'b0) $display("FAIL rst_cvalid: got %b want 0", core_valid_o); else n_pass++;
        @(negedge clk_i);
        rst_ni = 1'b1;
        tick();
    endtask

    task automatic test_fill_order();
        vec_context_t exp_ctx;
        for (int i = 1; i <= 4; i++) begin
            offer(i);
            #1;
            n_chk++; if (ready_o !== 1'b1) $display("FAIL fill_ready_%0d: got %b want 1", i, ready_o); else n_pass++;
            tick();
        end
        offer(9);
        #1;
        n_chk++; if (ready_o !== 1'b0) $display("FAIL full_ready: got %b want 0", ready_o); else n_pass++;
        n_chk++; if (count_o !== 3'd4) $display("FAIL full_count: got %0d want 4", count_o); else n_pass++;
        tick();
        valid_i = 1'b0;
        n_chk++; if (count_o !== 3'd4) $display("FAIL full_hold: got %0d want 4", count_o); else n_pass++;
        core_ready_i = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            core_done_i = (i > 1);
            exp_ctx = '{vtype: 8'(i), vl: 16'(i * 16)};
            #1;
            n_chk++; if (core_valid_o !== 1'b1) $display("FAIL drain_valid_%0d: got %b want 1", i, core_valid_o); else n_pass++;
            n_chk++; if (core_insn_id_o !== 8'(i)) $display("FAIL drain_id_%0d: got %0d want %0d", i, core_insn_id_o, i); else n_pass++;
            n_chk++; if (core_insn_o !== 32'h1000_0000 + 32'(i)) $display("FAIL drain_insn_%0d: got %h", i, core_insn_o); else n_pass++;
            n_chk++; if (core_scalar_reg_o !== 32'(i * 3)) $display("FAIL drain_scalar_%0d: got %0d want %0d", i, core_scalar_reg_o, i * 3); else n_pass++;
            n_chk++; if (core_vec_context_o !== exp_ctx) $display("FAIL drain_ctx_%0d: got %h want %h", i, core_vec_context_o, exp_ctx); else n_pass++;
            tick();
        end
        core_ready_i = 1'b0;
        core_done_i  = 1'b1;
        tick();
        core_done_i  = 1'b0;
        n_chk++; if (count_o !== 3'd0) $display("FAIL drain_count: got %0d want 0", count_o); else n_pass++;
        n_chk++; if (outstanding_o !== 2'd0) $display("FAIL drain_outst: got %0d want 0", outstanding_o); else n_pass++;
        n_chk++; if (done_underflow_o !== 1'b0) $display("FAIL drain_uflow: got %b want 0", done_underflow_o); else n_pass++;
    endtask

    task automatic test_max_outstanding();
        for (int i = 5; i <= 7; i++) begin
            offer(i);
            tick();
        end
        valid_i = 1'b0;
        core_ready_i = 1'b1;
        for (int i = 5; i <= 6; i++) begin
            #1;
            n_chk++; if (core_insn_id_o !== 8'(i)) $display("FAIL credit_id_%0d: got %0d want %0d", i, core_insn_id_o, i); else n_pass++;
            tick();
        end
        n_chk++; if (core_valid_o !== 1'b0) $display("FAIL credit_stall: got %b want 0", core_valid_o); else n_pass++;
        n_chk++; if (outstanding_o !== 2'd2) $display("FAIL credit_outst: got %0d want 2", outstanding_o); else n_pass++;
        n_chk++; if (count_o !== 3'd1) $display("FAIL credit_count: got %0d want 1", count_o); else n_pass++;
        core_done_i = 1'b1;
        tick();
        core_done_i = 1'b0;
        #1;
        n_chk++; if (core_valid_o !== 1'b1) $display("FAIL credit_resume: got %b want 1", core_valid_o); else n_pass++;
        n_chk++; if (core_insn_id_o !== 8'd7) $display("FAIL credit_id_7: got %0d want 7", core_insn_id_o); else n_pass++;
        tick();
        core_ready_i = 1'b0;
        n_chk++; if (outstanding_o !== 2'd2) $display("FAIL credit_outst2: got %0d want 2", outstanding_o); else n_pass++;
        core_done_i = 1'b1;
        tick();
        tick();
        core_done_i = 1'b0;
        n_chk++; if (outstanding_o !== 2'd0) $display("FAIL credit_retire: got %0d want 0", outstanding_o); else n_pass++;
    endtask

    task automatic test_back_to_back();
        offer(20);
        tick();
        core_ready_i = 1'b1;
        core_done_i  = 1'b1;
        for (int k = 0; k < 10; k++) begin
            offer(21 + k);
            #1;
            n_chk++; if (core_valid_o !== 1'b1) $display("FAIL b2b_valid_%0d: got %b want 1", k, core_valid_o); else n_pass++;
            n_chk++; if (core_insn_id_o !== 8'(20 + k)) $display("FAIL b2b_id_%0d: got %0d want %0d", k, core_insn_id_o, 20 + k); else n_pass++;
            n_chk++; if (count_o !== 3'd1) $display("FAIL b2b_count_%0d: got %0d want 1", k, count_o); else n_pass++;
            tick();
        end
        valid_i = 1'b0;
        #1;
        n_chk++; if (core_insn_id_o !== 8'd30) $display("FAIL b2b_last: got %0d want 30", core_insn_id_o); else n_pass++;
        tick();
        core_ready_i = 1'b0;
        core_done_i  = 1'b0;
        n_chk++; if (count_o !== 3'd0) $display("FAIL b2b_empty: got %0d want 0", count_o); else n_pass++;
        n_chk++; if (outstanding_o !== 2'd0) $display("FAIL b2b_outst: got %0d want 0", outstanding_o); else n_pass++;
        n_chk++; if (done_underflow_o !== 1'b0) $display("FAIL b2b_uflow: got %b want 0", done_underflow_o); else n_pass++;
    endtask

    task automatic test_flush();
        offer(39);
        tick();
        valid_i = 1'b0;
        core_ready_i = 1'b1;
        tick();
        core_ready_i = 1'b0;
        for (int i = 40; i <= 42; i++) begin
            offer(i);
            tick();
        end
        offer(99);
        flush_i = 1'b1;
        #1;
        n_chk++; if (ready_o !== 1'b0) $display("FAIL flush_ready: got %b want 0", ready_o); else n_pass++;
        n_chk++; if (core_valid_o !== 1'b0) $display("FAIL flush_cvalid: got %b want 0", core_valid_o); else n_pass++;
        tick();
        flush_i = 1'b0;
        valid_i = 1'b0;
        #1;
        n_chk++; if (count_o !== 3'd0) $display("FAIL flush_count: got %0d want 0", count_o); else n_pass++;
        n_chk++; if (outstanding_o !== 2'd1) $display("FAIL flush_outst: got %0d want 1", outstanding_o); else n_pass++;
        n_chk++; if (ready_o !== 1'b1) $display("FAIL flush_ready_after: got %b want 1", ready_o); else n_pass++;
        n_chk++; if (core_valid_o !== 1'b0) $display("FAIL flush_cvalid_after: got %b want 0", core_valid_o); else n_pass++;
        offer(50);
        tick();
        valid_i = 1'b0;
        flush_i = 1'b1;
        core_done_i = 1'b1;
        tick();
        flush_i = 1'b0;
        core_done_i = 1'b0;
        n_chk++; if (count_o !== 3'd0) $display("FAIL flush_done_count: got %0d want 0", count_o); else n_pass++;
        n_chk++; if (outstanding_o !== 2'd0) $display("FAIL flush_done_outst: got %0d want 0", outstanding_o); else n_pass++;
        offer(51);
        tick();
        valid_i = 1'b0;
        #1;
        n_chk++; if (core_insn_id_o !== 8'd51) $display("FAIL flush_refill_id: got %0d want 51", core_insn_id_o); else n_pass++;
        n_chk++; if (count_o !== 3'd1) $display("FAIL flush_refill_count: got %0d want 1", count_o); else n_pass++;
    endtask

    task automatic test_underflow();
        core_ready_i = 1'b1;
        core_done_i  = 1'b1;
        tick();
        core_ready_i = 1'b0;
        n_chk++; if (outstanding_o !== 2'd0) $display("FAIL popdone_outst: got %0d want 0", outstanding_o); else n_pass++;
        n_chk++; if (done_underflow_o !== 1'b0) $display("FAIL popdone_uflow: got %b want 0", done_underflow_o); else n_pass++;
        tick();
        core_done_i = 1'b0;
        n_chk++; if (done_underflow_o !== 1'b1) $display("FAIL uflow_set: got %b want 1", done_underflow_o); else n_pass++;
        n_chk++; if (outstanding_o !== 2'd0) $display("FAIL uflow_outst: got %0d want 0", outstanding_o); else n_pass++;
        repeat (3) tick();
        n_chk++; if (done_underflow_o !== 1'b1) $display("FAIL uflow_sticky: got %b want 1", done_underflow_o); else n_pass++;
    endtask

    task automatic test_async_reset();
        for (int i = 70; i <= 73; i++) begin
            offer(i);
            tick();
        end
        valid_i = 1'b0;
        core_ready_i = 1'b1;
        tick();
        tick();
        core_ready_i = 1'b0;
        offer(74);
        tick();
        valid_i = 1'b0;
        n_chk++; if (count_o !== 3'd3) $display("FAIL pre_rst_count: got %0d want 3", count_o); else n_pass++;
        n_chk++; if (outstanding_o !== 2'd2) $display("FAIL pre_rst_outst: got %0d want 2", outstanding_o); else n_pass++;
        #3;
        rst_ni = 1'b0;
        #1;
        n_chk++; if (count_o !== 3'd0) $display("FAIL arst_count: got %0d want 0", count_o); else n_pass++;
        n_chk++; if (outstanding_o !== 2'd0) $display("FAIL arst_outst: got %0d want 0", outstanding_o); else n_pass++;
        n_chk++; if (done_underflow_o !== 1'b0) $display("FAIL arst_uflow: got %b want 0", done_underflow_o); else n_pass++;
        n_chk++; if (ready_o !== 1'b1) $display("FAIL arst_ready: got %b want 1", ready_o); else n_pass++;
        n_chk++; if (core_valid_o !== 1'b0) $display("FAIL arst_cvalid: got %b want 0", core_valid_o); else n_pass++;
        @(negedge clk_i);
        rst_ni = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_fill_order();
        test_max_outstanding();
        test_back_to_back();
        test_flush();
        test_underflow();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/vinsn_issue_queue.md
VINSN_ISSUE_QUEUE -- requirements
Module: vinsn_issue_queue

Interface
REQ-001 Parameter Depth, default 4, number of FIFO entries; power of two, at least 2.
REQ-002 Parameter MaxOutstanding, default 4, maximum instructions issued to rvv_core and not yet done; at least 1.
REQ-003 clk_i  in  1  single clock; all state updates on its rising edge.
REQ-004 rst_ni  in  1  reset; asynchronous, active-low.
REQ-005 valid_i  in  1  scalar core offers an instruction.
REQ-006 ready_o  out  1  queue accepts the offer this cycle.
REQ-007 insn_i  in  32  raw instruction word.
REQ-008 insn_id_i  in  insn_id_t  instruction tag.
REQ-009 scalar_reg_i  in  xlen_t  scalar operand.
REQ-010 vec_context_i  in  vec_context_t  vtype/vl snapshot.
REQ-011 flush_i  in  1  discard all queued, unissued instructions.
REQ-012 core_valid_o  out  1  head entry offered to rvv_core.
REQ-013 core_ready_i  in  1  rvv_core accepts the head entry.
REQ-014 core_insn_o, core_insn_id_o, core_scalar_reg_o, core_vec_context_o  out  32/insn_id_t/xlen_t/vec_context_t  head entry fields.
REQ-015 core_done_i  in  1  rvv_core retired one instruction (driven from its done_o).
REQ-016 count_o  out  $clog2(Depth)+1  number of valid queue entries.
REQ-017 outstanding_o  out  $clog2(MaxOutstanding)+1  number of issued, not-done instructions.
REQ-018 done_underflow_o  out  1  sticky error flag.

Function
REQ-019 Entries SHALL be stored in a circular buffer with read and write pointers that wrap modulo Depth.
REQ-020 ready_o SHALL equal (count_o < Depth) && !flush_i, computed from registered state only.
REQ-021 A push SHALL occur when valid_i && ready_o; the entry becomes visible at the head no earlier than the next cycle (no combinational pass-through; minimum latency 1 cycle).
REQ-022 core_valid_o SHALL equal (count_o != 0) && (outstanding_o < MaxOutstanding) && !flush_i.
REQ-023 A pop SHALL occur when core_valid_o && core_ready_i; the head fields SHALL be held stable while core_valid_o is high and no pop occurs.
REQ-024 A simultaneous push and pop SHALL leave count_o unchanged and advance both pointers.
REQ-025 At full (count_o == Depth), a pop in a given cycle SHALL NOT enable a push in that same cycle.
REQ-026 outstanding_o SHALL increment on a pop and decrement on core_done_i; when both occur in the same cycle it SHALL remain unchanged.
REQ-027 core_done_i with outstanding_o == 0 and no pop in that cycle SHALL leave the counter at 0 and set done_underflow_o, which remains set until reset.
REQ-028 flush_i SHALL empty the queue on the next edge: count_o 0, pointers 0, no push or pop in the flush cycle.
REQ-029 flush_i SHALL NOT modify outstanding_o; core_done_i arriving in the flush cycle SHALL still decrement it.
REQ-030 Data storage SHALL need no reset; only pointers, counters and flags are reset.

Reset
REQ-031 While rst_ni is low: count_o 0, outstanding_o 0, done_underflow_o 0, ready_o 1, core_valid_o 0, both pointers 0.
REQ-032 Reset asserted mid-operation SHALL discard all entries and the outstanding count immediately, without waiting for a clock edge.

Verification
REQ-033 Depth=4: push ids 1..4 with core_ready_i=0 -> ready_o drops after the 4th push, count_o=4; then with core_ready_i=1, ids pop out in the order 1,2,3,4.
REQ-034 MaxOutstanding=2, 3 queued, core_ready_i=1, no done -> 2 pops, then core_valid_o=0 with outstanding_o=2; one core_done_i pulse -> the 3rd pops the following cycle.
REQ-035 Steady push+pop every cycle for 10 cycles with periodic done -> count_o stays 1, pointers wrap past Depth, data intact.
REQ-036 3 entries queued, flush_i pulse together with valid_i=1 -> no push in that cycle, count_o=0 next cycle, outstanding_o unchanged.
REQ-037 core_done_i with outstanding_o=0 -> done_underflow_o=1 and stays set; a same-cycle pop and done -> outstanding_o unchanged, no error.
REQ-038 rst_ni asserted with count_o=3 and outstanding_o=2 -> all outputs return to their reset values asynchronously, before the next clock edge.
